dmem_write_monitor: RTL and testbench



---
 rtl/dmem_write_monitor.sv | 127 ++++++++++++
 tb/tb_dmem_write_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_write_monitor.sv
// Pass/fail checker on the core->dmem write port: sticky verdict, store counter,
// no-verdict watchdog and a small show-ahead FIFO log of sampled stores.
//
// state | meaning
// ARMED | watching stores and the watchdog; counting and logging stores
// PASS  | PASS_DATA stored to PASS_ADR; terminal until reset
// FAIL  | illegal store address or watchdog expiry; terminal until reset
module dmem_write_monitor #(
   parameter logic [31:0] PASS_ADR    = 32'd100,
   parameter logic [31:0] PASS_DATA   = 32'd7,
   parameter logic [31:0] ALLOW_ADR   = 32'd96,
   parameter int          LOG_DEPTH   = 8,
   parameter int          CNT_W       = 16,
   parameter int          TIMEOUT_CYC = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemWrite,
   input  logic [31:0]      DataAdr,
   input  logic [31:0]      WriteData,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [1:0]       fail_code,
   output logic [CNT_W-1:0] write_count,
   input  logic             log_rd_en,
   output logic             log_empty,
   output logic             log_full,
   output logic             log_overflow,
   output logic [31:0]      log_adr,
   output logic [31:0]      log_data
);

   localparam int PTR_W = $clog2(LOG_DEPTH);
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] CYC_TC   = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [PTR_W:0]   LOG_FULL = (PTR_W + 1)'(LOG_DEPTH);

   typedef enum logic [1:0] {ARMED, PASS, FAIL} stateT;

   stateT            state, nextState;
   logic [1:0]       failCode, nextFailCode;
   logic [TMR_W-1:0] cycleCnt;
   logic [CNT_W-1:0] writeCnt;
   logic             storeArmed;

   logic [31:0]      adrMem  [LOG_DEPTH];
   logic [31:0]      dataMem [LOG_DEPTH];
   logic [PTR_W-1:0] rdPtr, wrPtr;
   logic [PTR_W:0]   logCount;
   logic             overflow;
   logic             logPush, logPop;

   assign storeArmed = MemWrite && (state == ARMED);

   // A store verdict takes priority over a coincident watchdog expiry.
   always_comb begin
      nextState    = state;
      nextFailCode = failCode;
      case (state)
         ARMED: begin
            if (storeArmed && DataAdr == PASS_ADR && WriteData == PASS_DATA) begin
               nextState = PASS;
            end else if (storeArmed && DataAdr != ALLOW_ADR) begin
               nextState    = FAIL;
               nextFailCode = 2'd1;
            end else if (cycleCnt == CYC_TC) begin
               nextState    = FAIL;
               nextFailCode = 2'd2;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ARMED;
         failCode <= 2'd0;
         cycleCnt <= '0;
         writeCnt <= '0;
      end else begin
         state    <= nextState;
         failCode <= nextFailCode;
         if (state == ARMED) cycleCnt <= cycleCnt + TMR_W'(1);
         if (storeArmed && writeCnt != '1) writeCnt <= writeCnt + CNT_W'(1);
      end
   end

   // A pop in the same cycle frees the slot, so a push into a full log still lands.
   assign logPop  = log_rd_en && !log_empty;
   assign logPush = storeArmed && (!log_full || logPop);

   always_ff @(posedge clk) begin
      if (reset) begin
         rdPtr    <= '0;
         wrPtr    <= '0;
         logCount <= '0;
         overflow <= 1'b0;
      end else begin
         if (logPush) wrPtr <= wrPtr + PTR_W'(1);
         if (logPop)  rdPtr <= rdPtr + PTR_W'(1);
         if (logPush && !logPop)      logCount <= logCount + (PTR_W + 1)'(1);
         else if (logPop && !logPush) logCount <= logCount - (PTR_W + 1)'(1);
         if (storeArmed && !logPush) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && logPush) begin
         adrMem[wrPtr]  <= DataAdr;
         dataMem[wrPtr] <= WriteData;
      end
   end

   assign done         = (state != ARMED);
   assign pass         = (state == PASS);
   assign fail         = (state == FAIL);
   assign fail_code    = failCode;
   assign write_count  = writeCnt;
   assign log_empty    = (logCount == '0);
   assign log_full     = (logCount == LOG_FULL);
   assign log_overflow = overflow;
   assign log_adr      = log_empty ? 32'd0 : adrMem[rdPtr];
   assign log_data     = log_empty ? 32'd0 : dataMem[rdPtr];

endmodule

// File: tb/tb_dmem_write_monitor.sv
// Directed and random stimulus for dmem_write_monitor, checked every cycle
// against a queue-based reference model of the pass/fail rules.
module tb_dmem_write_monitor;

   localparam int TO    = 20;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;
   logic        log_rd_en = 1'b0;
   logic        done, pass, fail;
   logic [1:0]  fail_code;
   logic [15:0] write_count;
   logic        log_empty, log_full, log_overflow;
   logic [31:0] log_adr, log_data;

   dmem_write_monitor #(.LOG_DEPTH(DEPTH), .CNT_W(16), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .done(done), .pass(pass), .fail(fail),
      .fail_code(fail_code), .write_count(write_count), .log_rd_en(log_rd_en),
      .log_empty(log_empty), .log_full(log_full), .log_overflow(log_overflow),
      .log_adr(log_adr), .log_data(log_data)
   );

   always #5 clk = ~clk;

   int checkCnt = 0;
   int failCnt  = 0;

   // reference model: verdict 0 = undecided, 1 = pass, 2 = fail
   int          mVerdict, mCode, mWrites, mCycles;
   bit          mOvf;
   logic [63:0] mLog[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCnt++;
      if (obs !== exp) begin
         failCnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic modelEdge();
      bit storeNow, popNow;
      if (reset) begin
         mVerdict = 0; mCode = 0; mWrites = 0; mCycles = 0; mOvf = 0;
         mLog.delete();
         return;
      end
      storeNow = MemWrite && mVerdict == 0;
      popNow   = log_rd_en && mLog.size() > 0;
      if (mVerdict == 0) begin
         if (storeNow && DataAdr == 100 && WriteData == 7) mVerdict = 1;
         else if (storeNow && DataAdr != 96) begin mVerdict = 2; mCode = 1; end
         else if (mCycles == TO - 1) begin mVerdict = 2; mCode = 2; end
         mCycles++;
      end
      if (popNow) void'(mLog.pop_front());
      if (storeNow) begin
         if (mWrites < 65535) mWrites++;
         if (mLog.size() < DEPTH) mLog.push_back({DataAdr, WriteData});
         else mOvf = 1;
      end
   endtask

   task automatic checkAll();
      logic [63:0] head;
      head = (mLog.size() > 0) ? mLog[0] : 64'd0;
      chk("done", done, mVerdict != 0);
      chk("pass", pass, mVerdict == 1);
      chk("fail", fail, mVerdict == 2);
      chk("fail_code", fail_code, mCode);
      chk("write_count", write_count, mWrites);
      chk("log_empty", log_empty, mLog.size() == 0);
      chk("log_full", log_full, mLog.size() == DEPTH);
      chk("log_overflow", log_overflow, mOvf);
      chk("log_adr", log_adr, head[63:32]);
      chk("log_data", log_data, head[31:0]);
   endtask

   task automatic tick(input bit rst, input bit we, input logic [31:0] adr,
                       input logic [31:0] dat, input bit rd);
      reset = rst; MemWrite = we; DataAdr = adr; WriteData = dat; log_rd_en = rd;
      @(posedge clk);
      modelEdge();
      #1;
      reset = 0; MemWrite = 0; DataAdr = '0; WriteData = '0; log_rd_en = 0;
      checkAll();
   endtask

   task automatic doReset();
      tick(1, 0, 0, 0, 0);
   endtask

   task automatic store(input logic [31:0] adr, input logic [31:0] dat);
      tick(0, 1, adr, dat, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
   endtask

   initial begin
      bit          rst, we, rd;
      logic [31:0] adr, dat;
      int          r;

      // pass sequence and log readback
      doReset();
      chk("rst_empty", log_empty, 1'b1);
      chk("rst_done", done, 1'b0);
      store(96, 3); store(96, 5); store(100, 7);
      chk("seq_pass", pass, 1'b1);
      chk("seq_count", write_count, 16'd3);
      chk("pop1", {log_adr, log_data}, {32'd96, 32'd3});  tick(0, 0, 0, 0, 1);
      chk("pop2", {log_adr, log_data}, {32'd96, 32'd5});  tick(0, 0, 0, 0, 1);
      chk("pop3", {log_adr, log_data}, {32'd100, 32'd7}); tick(0, 0, 0, 0, 1);
      chk("pop_empty", log_empty, 1'b1);
      tick(0, 0, 0, 0, 1);

      // illegal address, then later stores ignored
      doReset();
      store(104, 1);
      chk("illegal_code", fail_code, 2'd1);
      store(100, 7);
      chk("illegal_nopass", pass, 1'b0);
      chk("illegal_count", write_count, 16'd1);

      // wrong data at pass address
      doReset();
      store(100, 8);
      chk("wrongdata_code", fail_code, 2'd1);

      // watchdog expiry and coincident pass store
      doReset();
      idle(TO - 1);
      chk("to_early", fail, 1'b0);
      idle(1);
      chk("to_code", fail_code, 2'd2);
      doReset();
      idle(TO - 1);
      store(100, 7);
      chk("to_storewins", pass, 1'b1);

      // log overflow, then push+pop while full
      doReset();
      for (int i = 0; i < 9; i++) store(96, i);
      chk("ovf_flag", log_overflow, 1'b1);
      chk("ovf_count", write_count, 16'd9);
      tick(0, 1, 96, 32'h55, 1);
      chk("pushpop_full", log_full, 1'b1);
      for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 1);
      chk("drained", log_empty, 1'b1);

      // reset out of PASS re-arms
      doReset();
      store(100, 7);
      doReset();
      chk("rearm_pass", pass, 1'b0);
      store(96, 1);
      chk("rearm_count", write_count, 16'd1);

      // random traffic
      doReset();
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         we  = $urandom_range(0, 1) == 1;
         rd  = $urandom_range(0, 2) == 0;
         r   = $urandom_range(0, 19);
         if (r == 0) begin
            adr = 100;
            dat = $urandom_range(0, 1) ? 32'd7 : $urandom;
         end else if (r == 1) begin
            adr = 104; dat = $urandom;
         end else if (r == 2) begin
            adr = $urandom; dat = $urandom;
         end else begin
            adr = 96; dat = $urandom;
         end
         tick(rst, we, adr, dat, rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
      $finish;
   end

endmodule
